// File: rtl/magnitude_sar_search.sv
`default_nettype none
// ============================================================================
//  Module   : magnitude_sar_search
//  Purpose  : MSB-first successive-approximation search that owns operand B of
//             an external magnitude comparator and recovers the unknown value
//             held on its operand A. Exits early on EQ and flags any sample
//             where the LT/EQ/GT flags are not one-hot.
//  Revision : 1.0  initial release
// ============================================================================
module magnitude_sar_search #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [WIDTH-1:0]           cmp_b,
    input  logic                       cmp_lt,
    input  logic                       cmp_eq,
    input  logic                       cmp_gt,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           result,
    output logic [$clog2(WIDTH+1)-1:0] steps,
    output logic                       err
);

    localparam int IW  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int SW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int STW = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_MSB      = C_ONE << (WIDTH - 1);
    localparam logic [IW-1:0]    C_IDX_TOP  = IW'(WIDTH - 1);
    localparam logic [SW-1:0]    C_SETTLE_M = SW'(SETTLE - 1);
    localparam logic [STW-1:0]   C_STEP_INC = STW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q,  state_d;
    logic [WIDTH-1:0]  acc_q,    acc_d;
    logic [IW-1:0]     idx_q,    idx_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [STW-1:0]    steps_q,  steps_d;
    logic [WIDTH-1:0]  cmp_b_q,  cmp_b_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              err_q,    err_d;

    logic [WIDTH-1:0]  w_bit;
    logic [WIDTH-1:0]  w_acc_new;
    logic [2:0]        w_flags;
    logic              w_onehot;

    // State and datapath registers; reset wins over any search in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            settle_q <= '0;
            steps_q  <= '0;
            cmp_b_q  <= '0;
            result_q <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            steps_q  <= steps_d;
            cmp_b_q  <= cmp_b_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: launch, settle, sample-and-refine, report.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        settle_d  = settle_q;
        steps_d   = steps_q;
        cmp_b_d   = cmp_b_q;
        result_d  = result_q;
        err_d     = err_q;
        w_bit     = C_ONE << idx_q;
        w_flags   = {cmp_lt, cmp_eq, cmp_gt};
        w_onehot  = (w_flags == 3'b100) || (w_flags == 3'b010) || (w_flags == 3'b001);
        // GT means A is above the candidate, so the trial bit belongs in A.
        w_acc_new = cmp_gt ? cmp_b_q : acc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    idx_d    = C_IDX_TOP;
                    cmp_b_d  = C_MSB;
                    steps_d  = '0;
                    err_d    = 1'b0;
                    settle_d = C_SETTLE_M;
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - SW'(1);
                end else begin
                    steps_d = steps_q + C_STEP_INC;
                    if (!w_onehot) begin
                        // Report the bits already proven good, not the suspect candidate.
                        err_d    = 1'b1;
                        result_d = acc_q;
                        cmp_b_d  = '0;
                        state_d  = S_DONE;
                    end else if (cmp_eq) begin
                        result_d = cmp_b_q;
                        cmp_b_d  = '0;
                        state_d  = S_DONE;
                    end else begin
                        acc_d = w_acc_new;
                        if (idx_q == '0) begin
                            result_d = w_acc_new;
                            cmp_b_d  = '0;
                            state_d  = S_DONE;
                        end else begin
                            idx_d    = idx_q - IW'(1);
                            cmp_b_d  = w_acc_new | (w_bit >> 1);
                            settle_d = C_SETTLE_M;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmp_b  = cmp_b_q;
    assign busy   = (state_q == S_DRIVE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign steps  = steps_q;
    assign err    = err_q;

endmodule
`default_nettype wire
